// File: rtl/up_counter_ld.sv
// up_counter_ld: modulo-MODULUS up-counter with active-low count enable,
// synchronous parallel load, combinational terminal count and a registered
// wrap pulse. TC is combinational so that a synchronous cascade can use the
// inverted TC of one stage as the active-low EC of the next.
module up_counter_ld #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             r,
  input  logic             EC,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [31:0]      MOD_U  = 32'(MODULUS);
  localparam logic [WIDTH-1:0] Q_LAST = WIDTH'(MODULUS - 1);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("up_counter_ld: WIDTH must be in 2..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("up_counter_ld: MODULUS must be in 2..2**WIDTH");
  end

  logic [31:0]      d_ext;
  logic [31:0]      q_ext;
  logic             d_legal;
  logic             q_legal;
  logic             at_last;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_load;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // Range checks are done at 32 bits so MODULUS = 2**WIDTH needs no special case.
  assign d_ext   = 32'(D);
  assign q_ext   = 32'(Q);
  assign d_legal = (d_ext < MOD_U);
  assign q_legal = (q_ext < MOD_U);
  assign at_last = (Q == Q_LAST);

  // An out-of-range load value lands on 0; an out-of-range Q (only reachable
  // by forcing) also returns to 0 on the next count edge.
  assign q_load = d_legal ? D : '0;
  assign q_inc  = (at_last || !q_legal) ? '0 : Q + WIDTH'(1);

  assign TC = at_last && !EC;

  // Next-state selection: load beats count beats hold; only a count from the
  // last value raises the wrap pulse.
  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    if (LD) begin
      q_next    = q_load;
      wrap_next = 1'b0;
    end else if (!EC) begin
      q_next    = q_inc;
      wrap_next = at_last;
    end
  end

  // Count and wrap registers, cleared asynchronously by r.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else begin
      Q    <= q_next;
      WRAP <= wrap_next;
    end
  end

endmodule

// File: tb/tb_up_counter_ld.sv
// Bench for up_counter_ld: a mod-16 and a mod-10 instance share stimulus,
// and a two-stage mod-16 cascade runs alongside. Expectations come from
// integer models of each counter's value.
module tb_up_counter_ld;

  localparam int HEX_M = 16;
  localparam int DEC_M = 10;

  logic       clk;
  logic       r;
  logic       ec;
  logic       ld;
  logic [3:0] d;
  logic       lo_ec;

  logic [3:0] q_hex, q_dec, q_lo, q_hi;
  logic       tc_hex, tc_dec, tc_lo, tc_hi;
  logic       wrap_hex, wrap_dec, wrap_lo, wrap_hi;
  logic       hi_ec;

  int checks;
  int failures;

  int m_hex, m_dec, m_cas;
  int m_hex_w, m_dec_w, m_lo_w, m_hi_w;

  up_counter_ld #(.WIDTH(4), .MODULUS(HEX_M)) u_hex (
    .clk(clk), .r(r), .EC(ec), .LD(ld), .D(d), .Q(q_hex), .TC(tc_hex), .WRAP(wrap_hex)
  );

  up_counter_ld #(.WIDTH(4), .MODULUS(DEC_M)) u_dec (
    .clk(clk), .r(r), .EC(ec), .LD(ld), .D(d), .Q(q_dec), .TC(tc_dec), .WRAP(wrap_dec)
  );

  up_counter_ld #(.WIDTH(4), .MODULUS(16)) u_lo (
    .clk(clk), .r(r), .EC(lo_ec), .LD(1'b0), .D(4'd0), .Q(q_lo), .TC(tc_lo), .WRAP(wrap_lo)
  );

  assign hi_ec = ~tc_lo;

  up_counter_ld #(.WIDTH(4), .MODULUS(16)) u_hi (
    .clk(clk), .r(r), .EC(hi_ec), .LD(1'b0), .D(4'd0), .Q(q_hi), .TC(tc_hi), .WRAP(wrap_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hex = 0; m_dec = 0; m_cas = 0;
    m_hex_w = 0; m_dec_w = 0; m_lo_w = 0; m_hi_w = 0;
  endtask

  task automatic check_outputs();
    chk_val("hex_q", 32'(q_hex), m_hex);
    chk_val("hex_wrap", 32'(wrap_hex), m_hex_w);
    chk_val("dec_q", 32'(q_dec), m_dec);
    chk_val("dec_wrap", 32'(wrap_dec), m_dec_w);
    chk_val("cas_value", 32'({q_hi, q_lo}), m_cas);
    chk_val("lo_wrap", 32'(wrap_lo), m_lo_w);
    chk_val("hi_wrap", 32'(wrap_hi), m_hi_w);
  endtask

  // One clock cycle: apply inputs at the falling edge, check TC before the
  // rising edge, advance the models, then check registered outputs.
  task automatic drive(input bit ec_v, input bit ld_v, input int d_v, input bit lo_ec_v);
    int lo, hi;
    @(negedge clk);
    ec = ec_v; ld = ld_v; d = 4'(d_v); lo_ec = lo_ec_v;
    #1;
    lo = m_cas % 16;
    hi = m_cas / 16;
    chk_val("hex_tc", 32'(tc_hex), 32'(m_hex == HEX_M - 1 && !ec_v));
    chk_val("dec_tc", 32'(tc_dec), 32'(m_dec == DEC_M - 1 && !ec_v));
    chk_val("lo_tc", 32'(tc_lo), 32'(lo == 15 && !lo_ec_v));
    chk_val("hi_tc", 32'(tc_hi), 32'(hi == 15 && lo == 15 && !lo_ec_v));
    @(posedge clk);
    if (ld_v) begin
      m_hex = d_v;
      m_dec = (d_v < DEC_M) ? d_v : 0;
      m_hex_w = 0; m_dec_w = 0;
    end else if (!ec_v) begin
      m_hex_w = (m_hex == HEX_M - 1) ? 1 : 0;
      m_dec_w = (m_dec == DEC_M - 1) ? 1 : 0;
      m_hex = (m_hex + 1) % HEX_M;
      m_dec = (m_dec + 1) % DEC_M;
    end else begin
      m_hex_w = 0; m_dec_w = 0;
    end
    m_lo_w = (lo == 15 && !lo_ec_v) ? 1 : 0;
    m_hi_w = (m_cas == 255 && !lo_ec_v) ? 1 : 0;
    if (!lo_ec_v) m_cas = (m_cas + 1) % 256;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    r = 1'b0; ec = 1'b1; ld = 1'b0; d = 4'd0; lo_ec = 1'b1;
    model_reset();
    @(negedge clk);
    r = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    r = 1'b0; ec = 1'b1; ld = 1'b0; d = 4'd0; lo_ec = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk_val("reset_tc", 32'({tc_hex, tc_dec, tc_lo, tc_hi}), 32'd0);
    @(negedge clk);
    r = 1'b1;

    // Free run from reset: 20 counting cycles.
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 0, 1'b0);
    chk_val("free_run_end", 32'(q_hex), 32'd4);

    // Reach Q = 9, then reset between clock edges.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 0, 1'b0);
    chk_val("pre_reset_q", 32'(q_hex), 32'd9);
    #2;
    r = 1'b0;
    #1;
    model_reset();
    chk_val("async_rst_q", 32'(q_hex), 32'd0);
    chk_val("async_rst_wrap", 32'({wrap_hex, wrap_dec, wrap_lo, wrap_hi}), 32'd0);
    chk_val("async_rst_tc", 32'({tc_hex, tc_dec, tc_lo, tc_hi}), 32'd0);
    ec = 1'b1; lo_ec = 1'b1;
    @(negedge clk);
    r = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 0, 1'b1);

    // Modulo-10 sequence, then out-of-range and in-range loads.
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b0, 0, 1'b1);
    chk_val("dec_after_11", 32'(q_dec), 32'd1);
    drive(1'b1, 1'b1, 12, 1'b1);
    chk_val("dec_load_12", 32'(q_dec), 32'd0);
    drive(1'b1, 1'b1, 7, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 1'b1);
    chk_val("dec_wrap_after_7", 32'({q_dec, wrap_dec}), 32'({4'd0, 1'b1}));

    // Load priority over a pending wrap.
    drive(1'b1, 1'b1, 15, 1'b1);
    drive(1'b0, 1'b1, 3, 1'b1);
    chk_val("ld_prio", 32'({q_hex, wrap_hex}), 32'({4'd3, 1'b0}));
    drive(1'b0, 1'b0, 0, 1'b1);
    chk_val("ld_prio_next", 32'(q_hex), 32'd4);

    // Enable gating: toggling EC from 0 gives half the edges.
    drive(1'b1, 1'b1, 0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'(i % 2), 1'b0, 0, 1'b1);
    chk_val("gated_q", 32'(q_hex), 32'd4);
    drive(1'b1, 1'b1, 15, 1'b1);
    drive(1'b1, 1'b0, 0, 1'b1);
    chk_val("tc_gated_at_15", 32'(tc_hex), 32'd0);

    // Cascade: 40 counting cycles from reset.
    do_reset();
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 0, 1'b0);
    chk_val("cascade_40", 32'({q_hi, q_lo}), 32'd40);

    // Randomized traffic on all inputs.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
